// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline result, long-latency result stream, register-file
// write port and the hazard busy mask.
interface wb_port_arbiter_if;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    modport master (
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data, lu_valid, lu_rd, lu_data,
        input  pipe_stall, lu_ready, rf_we, rf_waddr, rf_wdata, busy_mask
    );

    modport slave (
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data, lu_valid, lu_rd, lu_data,
        output pipe_stall, lu_ready, rf_we, rf_waddr, rf_wdata, busy_mask
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback
// result and a FIFO of long-latency results, with starvation-forced drains and WAW kill.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [SC_W-1:0]  starve_cnt;

    logic        rf_we_p1;
    logic [4:0]  rf_waddr_p1;
    logic [31:0] rf_wdata_p1;

    logic pipe_req, fifo_req, force_drain, grant_pipe, grant_fifo;
    logic lu_ready, push, store, store_live;
    logic [31:0] busy;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] x);
        return (x >= SC_W'(STARVE_LIMIT)) ? SC_W'(STARVE_LIMIT) : x + SC_W'(1);
    endfunction

    // Stage p0: request terms, grant priority and push decode
    always_comb begin
        pipe_req    = bus.pipe_wb_valid && (bus.pipe_wb_rd != 5'd0);
        fifo_req    = (count != '0);
        force_drain = fifo_req && (starve_cnt >= SC_W'(STARVE_LIMIT));
        grant_pipe  = !force_drain && pipe_req;
        grant_fifo  = force_drain || (!pipe_req && fifo_req);
        lu_ready    = (count < CNT_W'(DEPTH));
        push        = bus.lu_valid && lu_ready;
        store       = push && (bus.lu_rd != 5'd0);
        // A same-cycle pipeline write to the same rd supersedes the older long-latency result.
        store_live  = !(grant_pipe && (bus.pipe_wb_rd == bus.lu_rd));
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) busy[rd_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (store) begin
            rd_q[tail]   <= bus.lu_rd;
            data_q[tail] <= bus.lu_data;
        end
    end

    // Stage p1: registered write port and FIFO control state
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_p1    <= 1'b0;
            rf_waddr_p1 <= '0;
            rf_wdata_p1 <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            starve_cnt  <= '0;
            live_q      <= '0;
        end else begin
            if (grant_pipe) begin
                rf_we_p1    <= 1'b1;
                rf_waddr_p1 <= bus.pipe_wb_rd;
                rf_wdata_p1 <= bus.pipe_wb_data;
                starve_cnt  <= fifo_req ? sat_inc(starve_cnt) : '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_q[i] == bus.pipe_wb_rd) live_q[i] <= 1'b0;
                end
            end else if (grant_fifo) begin
                rf_we_p1    <= live_q[head];
                rf_waddr_p1 <= rd_q[head];
                rf_wdata_p1 <= data_q[head];
                starve_cnt  <= '0;
                live_q[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end else begin
                rf_we_p1 <= 1'b0;
            end
            if (store) begin
                live_q[tail] <= store_live;
                tail         <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(store) - CNT_W'(grant_fifo);
        end
    end

    assign bus.pipe_stall = force_drain;
    assign bus.lu_ready   = lu_ready;
    assign bus.busy_mask  = busy;
    assign bus.rf_we      = rf_we_p1;
    assign bus.rf_waddr   = rf_waddr_p1;
    assign bus.rf_wdata   = rf_wdata_p1;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (DEPTH=4, STARVE_LIMIT=3).
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_stall;
        logic        e_ready;
        logic [31:0] e_busy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic pv, logic [4:0] prd, logic [31:0] pd,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic e_stall, logic e_ready, logic [31:0] e_busy,
                                logic e_we, logic [4:0] e_addr, logic [31:0] e_data);
        vec_t v;
        v.rst = rst; v.pv = pv; v.prd = prd; v.pd = pd;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.e_stall = e_stall; v.e_ready = e_ready; v.e_busy = e_busy;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset             = v.rst;
        bus.pipe_wb_valid = v.pv;
        bus.pipe_wb_rd    = v.prd;
        bus.pipe_wb_data  = v.pd;
        bus.lu_valid      = v.lv;
        bus.lu_rd         = v.lrd;
        bus.lu_data       = v.ld;
    endtask

    // Called 1 time unit after a rising edge: drive, check combinational outputs mid-cycle,
    // then check registered outputs 1 time unit after the next rising edge.
    task automatic step(input vec_t v, input int idx);
        drive(v);
        #4;
        chk("pipe_stall", idx, 32'(bus.pipe_stall), 32'(v.e_stall));
        chk("lu_ready",   idx, 32'(bus.lu_ready),   32'(v.e_ready));
        chk("busy_mask",  idx, bus.busy_mask,       v.e_busy);
        @(posedge clk);
        #1;
        chk("rf_we", idx, 32'(bus.rf_we), 32'(v.e_we));
        if (v.e_we || v.rst) begin
            chk("rf_waddr", idx, 32'(bus.rf_waddr), 32'(v.e_addr));
            chk("rf_wdata", idx, bus.rf_wdata, v.e_data);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Reset state
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_we",    -1, 32'(bus.rf_we),    32'd0);
        chk("reset_waddr", -1, 32'(bus.rf_waddr), 32'd0);
        chk("reset_wdata", -1, bus.rf_wdata,      32'd0);
        #4;
        chk("reset_ready", -1, 32'(bus.lu_ready),   32'd1);
        chk("reset_busy",  -1, bus.busy_mask,       32'd0);
        chk("reset_stall", -1, 32'(bus.pipe_stall), 32'd0);
        @(posedge clk);
        #1;

        //            rst pv prd pdata        lv lrd ldata         stl rdy busy         we addr data
        // Single push drained into idle slots
        tbl.push_back(mk(0, 0, 0,  0,           1, 5,  32'hAAAA0001, 0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h20,       1, 5,  32'hAAAA0001));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        // Starvation: forced drain on the 4th pipeline cycle with a pending entry
        tbl.push_back(mk(0, 1, 3,  32'h1234,    1, 7,  32'h77,       0, 1, 32'h0,        1, 3,  32'h1234));
        tbl.push_back(mk(0, 1, 3,  32'h1234,    0, 0,  0,            0, 1, 32'h80,       1, 3,  32'h1234));
        tbl.push_back(mk(0, 1, 3,  32'h1234,    0, 0,  0,            0, 1, 32'h80,       1, 3,  32'h1234));
        tbl.push_back(mk(0, 1, 3,  32'h1234,    0, 0,  0,            0, 1, 32'h80,       1, 3,  32'h1234));
        tbl.push_back(mk(0, 1, 3,  32'h1234,    0, 0,  0,            1, 1, 32'h80,       1, 7,  32'h77));
        tbl.push_back(mk(0, 1, 3,  32'h1234,    0, 0,  0,            0, 1, 32'h0,        1, 3,  32'h1234));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        // WAW kill by a later pipeline write
        tbl.push_back(mk(0, 0, 0,  0,           1, 9,  32'h1,        0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 1, 9,  32'h2,       0, 0,  0,            0, 1, 32'h200,      1, 9,  32'h2));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        // Fill to full under pipeline pressure; full blocks accept even with a pop
        tbl.push_back(mk(0, 1, 1,  32'h100,     1, 10, 32'hA,        0, 1, 32'h0,        1, 1,  32'h100));
        tbl.push_back(mk(0, 1, 1,  32'h101,     1, 11, 32'hB,        0, 1, 32'h400,      1, 1,  32'h101));
        tbl.push_back(mk(0, 1, 1,  32'h102,     1, 12, 32'hC,        0, 1, 32'hC00,      1, 1,  32'h102));
        tbl.push_back(mk(0, 1, 1,  32'h103,     1, 13, 32'hD,        0, 1, 32'h1C00,     1, 1,  32'h103));
        tbl.push_back(mk(0, 1, 1,  32'h104,     1, 14, 32'hE,        1, 0, 32'h3C00,     1, 10, 32'hA));
        tbl.push_back(mk(0, 1, 1,  32'h104,     1, 14, 32'hE,        0, 1, 32'h3800,     1, 1,  32'h104));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 0, 32'h7800,     1, 11, 32'hB));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h7000,     1, 12, 32'hC));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h6000,     1, 13, 32'hD));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h4000,     1, 14, 32'hE));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        // Same-cycle push and pipeline write to the same rd
        tbl.push_back(mk(0, 1, 4,  32'h44,      1, 4,  32'h99,       0, 1, 32'h0,        1, 4,  32'h44));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        // lu_rd==0 accepted but not stored; pipeline rd==0 is an idle slot
        tbl.push_back(mk(0, 0, 0,  0,           1, 0,  32'h55,       0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,           1, 6,  32'h66,       0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 1, 0,  32'hDEAD,    0, 0,  0,            0, 1, 32'h40,       1, 6,  32'h66));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        // Reset with three buffered entries discards them
        tbl.push_back(mk(0, 1, 2,  32'h200,     1, 20, 32'h20,       0, 1, 32'h0,        1, 2,  32'h200));
        tbl.push_back(mk(0, 1, 2,  32'h201,     1, 21, 32'h21,       0, 1, 32'h100000,   1, 2,  32'h201));
        tbl.push_back(mk(0, 1, 2,  32'h202,     1, 22, 32'h22,       0, 1, 32'h300000,   1, 2,  32'h202));
        tbl.push_back(mk(1, 1, 2,  32'h203,     0, 0,  0,            0, 1, 32'h700000,   0, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,           0, 0,  0,            0, 1, 32'h0,        0, 0,  0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback result and a long-latency unit (multi-cycle mul/div or load unit).
- The pipeline result is the output of the writeback select mux.
- Long-latency results are buffered in a small FIFO and drained into idle writeback slots. A starvation limit forces a drain by stalling the pipeline.
- Provides write-after-write (WAW) kill of stale buffered results and a busy mask for hazard detection.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 3, consecutive pipeline-granted cycles with a non-empty FIFO before a forced drain (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_wb_valid  in  1  pipeline writeback valid this cycle.
- pipe_wb_rd  in  5  pipeline destination register.
- pipe_wb_data  in  32  pipeline write data (writeback mux output).
- pipe_stall  out  1  combinational; pipeline must hold its WB stage this cycle.
- lu_valid  in  1  long-latency result offered.
- lu_rd  in  5  long-latency destination register.
- lu_data  in  32  long-latency result data.
- lu_ready  out  1  FIFO can accept; equals (count < DEPTH).
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  32  registered write data.
- busy_mask  out  32  bit r set when a live FIFO entry targets r; bit 0 is always 0.

Behaviour:
- Reset state (synchronous, takes precedence over everything):
  - rf_we=0, rf_waddr=0, rf_wdata=0; FIFO emptied (count=0); starve_cnt=0; all live bits cleared.
  - Hence lu_ready=1, busy_mask=0, pipe_stall=0 on the cycle after reset.
  - Reset mid-operation discards buffered results with no write.
- Push:
  - A result is accepted when lu_valid && lu_ready.
  - lu_rd==0 is accepted but not stored.
  - Otherwise the entry {rd, data, live=1} is written at the tail.
  - No same-cycle bypass: the earliest rf_we for an accepted result is 2 clocks after acceptance.
- Request terms:
  - pipe_req = pipe_wb_valid && pipe_wb_rd!=0.
  - fifo_req = count>0.
  - force = fifo_req && starve_cnt>=STARVE_LIMIT.
- Grant, evaluated each non-reset cycle in priority order:
  1. force: FIFO head granted; pipe_stall=1; pipeline inputs ignored; starve_cnt<=0.
  2. pipe_req: pipeline granted; starve_cnt<=starve_cnt+1 if fifo_req (saturating), else 0.
  3. fifo_req: FIFO head granted; starve_cnt<=0.
  4. none: rf_we<=0.
- Granted write: next cycle rf_we=1 with that rd and data.
  - Exception: a granted FIFO head with live=0 is popped with rf_we<=0 (the slot is consumed).
- pipe_stall is asserted only on a force cycle, including when pipe_wb_valid=0.
- WAW kill, on a pipeline-granted cycle with rd R:
  - Every stored entry with rd==R gets live<=0.
  - An entry pushed in the same cycle with rd==R is stored with live=0 (the long-latency result is older by definition).
- Pop and push in the same cycle: count unchanged. Head and tail pointers wrap modulo DEPTH.
- Full FIFO: lu_ready=0. The producer holds its data; no accept even if a pop occurs that cycle.
- busy_mask is combinational from the stored entries and reflects register state only (not same-cycle pushes).
- pipe_wb_valid with rd==0 writes nothing and counts as an idle slot for FIFO drain.

Test Plan:
- Reset, then push lu {rd=5, data=0xAAAA0001} with the pipeline idle -> busy_mask=0x20 next cycle; rf_we=1, rf_waddr=5, rf_wdata=0xAAAA0001 two cycles after accept; busy_mask=0 after the pop.
- Pipeline writes {rd=3, 0x1234} every cycle while 1 FIFO entry {rd=7} is pending -> three cycles rd=3 written; 4th cycle pipe_stall=1 and rd=7 written; pipeline {rd=3} written the following cycle.
- FIFO holds {rd=9, 0x1}; pipeline writes rd=9 data 0x2 -> entry killed, busy_mask bit9=0; later drain slot gives rf_we=0; final x9=0x2.
- Push 4 entries with the pipeline continuously busy (STARVE_LIMIT large) -> lu_ready=0 after 4th; a 5th lu_valid is not accepted; one pop raises lu_ready next cycle.
- Same cycle: lu push rd=4 and pipeline write rd=4 -> pipeline written; stored entry dead; no later write to x4.
- Assert reset with 3 entries buffered -> next cycle count=0, lu_ready=1, busy_mask=0, rf_we=0; no buffered write ever appears.
